// File: rtl/pt_config_loader.sv
// rtl/pt_config_loader.sv - serial config loader with shadow register and atomic commit to the AND array
module pt_config_loader #(
  parameter int PT_INPUTS = 6,
  parameter int NUM_PT    = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load_start,
  input  logic                          i_abort,
  input  logic                          i_conf_clear,
  input  logic                          i_cfg_bit,
  input  logic                          i_cfg_valid,
  output logic                          o_cfg_ready,
  output logic [PT_INPUTS*NUM_PT-1:0]   o_conf_out,
  output logic                          o_conf_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_aborted
);

  localparam int CFG_BITS = PT_INPUTS * NUM_PT;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CFG_BITS-1:0]   r_shadow;
  logic [CFG_BITS-1:0]   r_conf_out;
  logic                  r_conf_valid;
  logic                  r_cfg_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;
  logic                  w_transfer;

  // r_cfg_ready is high exactly while in SHIFT, so it doubles as the state qualifier
  assign w_transfer = i_cfg_valid & r_cfg_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shadow     <= '0;
      r_conf_out   <= '0;
      r_conf_valid <= 1'b0;
      r_cfg_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_conf_clear) begin
            r_conf_out   <= '0;
            r_conf_valid <= 1'b0;
          end
          if (i_load_start) begin
            r_state     <= S_SHIFT;
            r_bit_cnt   <= '0;
            r_shadow    <= '0;
            r_aborted   <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          // abort beats a simultaneous final transfer: the live config is left untouched
          if (i_abort) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shadow    <= '0;
            r_aborted   <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_transfer) begin
            r_shadow[r_bit_cnt] <= i_cfg_bit;
            r_bit_cnt           <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_IDX) begin
              r_state     <= S_COMMIT;
              r_cfg_ready <= 1'b0;
            end
          end
        end
        S_COMMIT: begin
          r_conf_out   <= r_shadow;
          r_conf_valid <= 1'b1;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_conf_out   = r_conf_out;
  assign o_conf_valid = r_conf_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_aborted    = r_aborted;

endmodule

// File: tb/tb_pt_config_loader.sv
// tb/tb_pt_config_loader.sv - directed bench for pt_config_loader
module tb_pt_config_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_load_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_conf_clear = 1'b0;
  logic        i_cfg_bit = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [11:0] o_conf_out;
  logic        o_conf_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  pt_config_loader #(.PT_INPUTS(6), .NUM_PT(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load_start (i_load_start),
    .i_abort      (i_abort),
    .i_conf_clear (i_conf_clear),
    .i_cfg_bit    (i_cfg_bit),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .o_conf_out   (o_conf_out),
    .o_conf_valid (o_conf_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_aborted    (o_aborted)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_conf_out"},   32'(o_conf_out), 32'h0);
    check({tag, "_conf_valid"}, 32'(o_conf_valid), 32'h0);
    check({tag, "_busy"},       32'(o_busy), 32'h0);
    check({tag, "_done"},       32'(o_done), 32'h0);
    check({tag, "_aborted"},    32'(o_aborted), 32'h0);
    check({tag, "_cfg_ready"},  32'(o_cfg_ready), 32'h0);
  endtask

  task automatic send_bits(input logic [11:0] val, input int lo, input int hi, input bit gaps);
    for (int i = lo; i < hi; i++) begin
      if (gaps) begin
        i_cfg_valid = 1'b0;
        tick();
        check("gap_cfg_ready", 32'(o_cfg_ready), 32'h1);
      end
      i_cfg_bit   = val[i];
      i_cfg_valid = 1'b1;
      tick();
      check("shift_no_done", 32'(o_done), 32'h0);
    end
    i_cfg_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [11:0] val, input bit gaps, input logic [11:0] prev);
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    check({tag, "_start_busy"},    32'(o_busy), 32'h1);
    check({tag, "_start_ready"},   32'(o_cfg_ready), 32'h1);
    check({tag, "_start_aborted"}, 32'(o_aborted), 32'h0);
    send_bits(val, 0, 12, gaps);
    check({tag, "_commit_ready"},  32'(o_cfg_ready), 32'h0);
    check({tag, "_commit_hold"},   32'(o_conf_out), 32'(prev));
    tick();
    check({tag, "_conf_out"},   32'(o_conf_out), 32'(val));
    check({tag, "_conf_valid"}, 32'(o_conf_valid), 32'h1);
    check({tag, "_done_hi"},    32'(o_done), 32'h1);
    check({tag, "_busy_lo"},    32'(o_busy), 32'h0);
    tick();
    check({tag, "_done_lo"},    32'(o_done), 32'h0);
    check({tag, "_conf_keep"},  32'(o_conf_out), 32'(val));
  endtask

  initial begin
    // reset
    tick();
    tick();
    check_idle_zero("reset");
    i_rst = 1'b0;
    tick();
    check_idle_zero("post_reset");

    // 0,0,1,1,0,0,1,0,1,0,1,1 with bit i at position i gives 12'hD4C
    do_load("t1", 12'hD4C, 1'b0, 12'h000);

    // clear in IDLE
    i_conf_clear = 1'b1;
    tick();
    i_conf_clear = 1'b0;
    check("t5_clear_out",   32'(o_conf_out), 32'h0);
    check("t5_clear_valid", 32'(o_conf_valid), 32'h0);

    // gapped valid, same result
    do_load("t2", 12'hD4C, 1'b1, 12'h000);

    // abort after 5 bits
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    send_bits(12'h123, 0, 5, 1'b0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t3_busy",      32'(o_busy), 32'h0);
    check("t3_aborted",   32'(o_aborted), 32'h1);
    check("t3_conf_out",  32'(o_conf_out), 32'hD4C);
    check("t3_valid",     32'(o_conf_valid), 32'h1);
    check("t3_ready",     32'(o_cfg_ready), 32'h0);
    tick();
    check("t3_no_done",   32'(o_done), 32'h0);
    check("t3_sticky",    32'(o_aborted), 32'h1);

    // abort coincident with the final bit
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    check("t4_aborted_clr", 32'(o_aborted), 32'h0);
    send_bits(12'hABC, 0, 11, 1'b0);
    i_cfg_bit   = 1'b1;
    i_cfg_valid = 1'b1;
    i_abort     = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    i_abort     = 1'b0;
    check("t4_busy",     32'(o_busy), 32'h0);
    check("t4_aborted",  32'(o_aborted), 32'h1);
    check("t4_conf_out", 32'(o_conf_out), 32'hD4C);
    tick();
    check("t4_no_done",  32'(o_done), 32'h0);
    check("t4_conf_out2", 32'(o_conf_out), 32'hD4C);
    check("t4_valid",    32'(o_conf_valid), 32'h1);

    // clear and start ignored in SHIFT; abort ignored in COMMIT
    i_load_start = 1'b1;
    tick();
    check("t5_shift_busy", 32'(o_busy), 32'h1);
    i_conf_clear = 1'b1;
    tick();
    tick();
    i_conf_clear = 1'b0;
    i_load_start = 1'b0;
    check("t5_shift_out",   32'(o_conf_out), 32'hD4C);
    check("t5_shift_valid", 32'(o_conf_valid), 32'h1);
    check("t5_shift_ready", 32'(o_cfg_ready), 32'h1);
    send_bits(12'h5A3, 0, 12, 1'b0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("commit_abort_out",  32'(o_conf_out), 32'h5A3);
    check("commit_abort_done", 32'(o_done), 32'h1);
    check("commit_abort_flag", 32'(o_aborted), 32'h0);

    // clear and start together in IDLE
    i_conf_clear = 1'b1;
    i_load_start = 1'b1;
    tick();
    i_conf_clear = 1'b0;
    i_load_start = 1'b0;
    check("both_out",   32'(o_conf_out), 32'h0);
    check("both_valid", 32'(o_conf_valid), 32'h0);
    check("both_busy",  32'(o_busy), 32'h1);
    send_bits(12'h0F0, 0, 12, 1'b0);
    tick();
    check("both_load_out", 32'(o_conf_out), 32'h0F0);

    // reset after 7 bits of a load
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    send_bits(12'hFFF, 0, 7, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_idle_zero("t6_rst");
    do_load("t6", 12'hFFF, 1'b0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
